// File: rtl/rs_multi.sv
// rs_multi -- multi-entry reservation station with CDB wakeup, age-ordered
// select and ROB-range rollback.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  stage enable; when low all state holds and nothing fires
//   dispatch_*          op write side; dispatch_ready = room, not rolling back
//   disp_*              op fields: dest tag, two source tags + ready, ROB slot, payload
//   cdb_valid/T_idx     NUM_CDB broadcast tags (port 0 in LSBs) for wakeup
//   rob_head_idx        oldest in-flight ROB slot, reference point for age
//   rollback_*          squash entries whose ROB slot lies in
//                       [rollback_idx, rollback_idx + rollback_diff] (mod NUM_ROB)
//   issue_*             oldest ready entry, presented combinationally
//   count               registered number of valid entries
module rs_multi #(
  parameter int NUM_ENTRY = 8,
  parameter int NUM_CDB   = 2,
  parameter int NUM_ROB   = 32,
  parameter int T_W       = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [T_W-1:0]                disp_T_idx,
  input  logic [T_W-1:0]                disp_T1_idx,
  input  logic [T_W-1:0]                disp_T2_idx,
  input  logic                          disp_T1_ready,
  input  logic                          disp_T2_ready,
  input  logic [$clog2(NUM_ROB)-1:0]    disp_ROB_idx,
  input  logic [PAYLOAD_W-1:0]          disp_payload,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*T_W-1:0]        cdb_T_idx,
  input  logic [$clog2(NUM_ROB)-1:0]    rob_head_idx,
  input  logic                          rollback_en,
  input  logic [$clog2(NUM_ROB)-1:0]    rollback_idx,
  input  logic [$clog2(NUM_ROB)-1:0]    rollback_diff,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [T_W-1:0]                issue_T_idx,
  output logic [T_W-1:0]                issue_T1_idx,
  output logic [T_W-1:0]                issue_T2_idx,
  output logic [$clog2(NUM_ROB)-1:0]    issue_ROB_idx,
  output logic [PAYLOAD_W-1:0]          issue_payload,
  output logic [$clog2(NUM_ENTRY):0]    count
);

  localparam int RW = $clog2(NUM_ROB);
  localparam int IW = $clog2(NUM_ENTRY);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_ENTRY);

  typedef struct packed {
    logic [T_W-1:0]       t;
    logic [T_W-1:0]       t1;
    logic [T_W-1:0]       t2;
    logic [RW-1:0]        rob;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  // Control state (reset) and entry data (no reset) are kept apart.
  logic [NUM_ENTRY-1:0] valid_q, t1_rdy_q, t2_rdy_q;
  logic [CW-1:0]        count_q;
  entry_t               data_q [NUM_ENTRY];

  logic [NUM_ENTRY-1:0] valid_d, t1_rdy_d, t2_rdy_d;
  logic [CW-1:0]        count_d, squash_cnt;
  logic [NUM_ENTRY-1:0] t1_ok, t2_ok, squash, elig;
  logic [RW-1:0]        age [NUM_ENTRY];
  logic [RW-1:0]        best_age;
  logic [IW-1:0]        sel_idx, free_idx;
  logic                 any_elig, dispatch_fire, issue_fire;

  // True when any enabled CDB port broadcasts this tag this cycle.
  function automatic logic cdb_match(input logic [T_W-1:0] tag,
                                     input logic [NUM_CDB-1:0] v,
                                     input logic [NUM_CDB*T_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (v[k] && tags[k*T_W +: T_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Wakeup, squash and eligibility per entry, then oldest-first select.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no latch is inferred.
    any_elig   = 1'b0;
    best_age   = '0;
    sel_idx    = '0;
    free_idx   = '0;
    squash_cnt = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      t1_ok[i]  = t1_rdy_q[i] | (en & cdb_match(data_q[i].t1, cdb_valid, cdb_T_idx));
      t2_ok[i]  = t2_rdy_q[i] | (en & cdb_match(data_q[i].t2, cdb_valid, cdb_T_idx));
      squash[i] = en & rollback_en & valid_q[i] &
                  (RW'(data_q[i].rob - rollback_idx) <= rollback_diff);
      elig[i]   = valid_q[i] & t1_ok[i] & t2_ok[i] & ~squash[i];
      age[i]    = RW'(data_q[i].rob - rob_head_idx);
      if (elig[i] && (!any_elig || age[i] < best_age)) begin
        any_elig = 1'b1;
        best_age = age[i];
        sel_idx  = IW'(i);
      end
      if (squash[i]) squash_cnt = squash_cnt + CW'(1);
    end
    // Descending scan leaves the lowest-index free slot.
    for (int i = NUM_ENTRY - 1; i >= 0; i--)
      if (!valid_q[i]) free_idx = IW'(i);
  end

  assign dispatch_ready = en && !rollback_en && (count_q < FULL);
  assign dispatch_fire  = dispatch_valid && dispatch_ready;
  assign issue_valid    = en && any_elig;
  assign issue_fire     = issue_valid && issue_ready;

  // Next control state. Slots freed this cycle still read valid in valid_q,
  // so free_idx never points at them until the following cycle.
  always_comb begin
    valid_d  = valid_q & ~squash;
    t1_rdy_d = t1_ok;
    t2_rdy_d = t2_ok;
    if (issue_fire) valid_d[sel_idx] = 1'b0;
    if (dispatch_fire) begin
      valid_d[free_idx]  = 1'b1;
      t1_rdy_d[free_idx] = disp_T1_ready | cdb_match(disp_T1_idx, cdb_valid, cdb_T_idx);
      t2_rdy_d[free_idx] = disp_T2_ready | cdb_match(disp_T2_idx, cdb_valid, cdb_T_idx);
    end
    count_d = count_q + CW'(dispatch_fire) - CW'(issue_fire) - squash_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      t1_rdy_q <= '0;
      t2_rdy_q <= '0;
      count_q  <= '0;
    end else if (en) begin
      valid_q  <= valid_d;
      t1_rdy_q <= t1_rdy_d;
      t2_rdy_q <= t2_rdy_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry data is not reset; valid_q gates every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (dispatch_fire)
      data_q[free_idx] <= '{t: disp_T_idx, t1: disp_T1_idx, t2: disp_T2_idx,
                            rob: disp_ROB_idx, payload: disp_payload};
  end

  assign issue_T_idx   = data_q[sel_idx].t;
  assign issue_T1_idx  = data_q[sel_idx].t1;
  assign issue_T2_idx  = data_q[sel_idx].t2;
  assign issue_ROB_idx = data_q[sel_idx].rob;
  assign issue_payload = data_q[sel_idx].payload;
  assign count         = count_q;

endmodule

// File: tb/tb_rs_multi.sv
// tb_rs_multi -- self-checking bench for rs_multi (default parameters).
// A cycle table covers dispatch, wakeup, bypass and age select; hand-written
// sequences cover fill, wrap-around age, backpressure, rollback, enable and
// asynchronous reset.
module tb_rs_multi;

  logic        clk = 1'b0;
  logic        rst_n, en, dispatch_valid, dispatch_ready;
  logic [5:0]  disp_T_idx, disp_T1_idx, disp_T2_idx;
  logic        disp_T1_ready, disp_T2_ready;
  logic [4:0]  disp_ROB_idx;
  logic [63:0] disp_payload;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_T_idx;
  logic [4:0]  rob_head_idx, rollback_idx, rollback_diff;
  logic        rollback_en, issue_valid, issue_ready;
  logic [5:0]  issue_T_idx, issue_T1_idx, issue_T2_idx;
  logic [4:0]  issue_ROB_idx;
  logic [63:0] issue_payload;
  logic [3:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  rs_multi dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .disp_T_idx(disp_T_idx), .disp_T1_idx(disp_T1_idx), .disp_T2_idx(disp_T2_idx),
    .disp_T1_ready(disp_T1_ready), .disp_T2_ready(disp_T2_ready),
    .disp_ROB_idx(disp_ROB_idx), .disp_payload(disp_payload),
    .cdb_valid(cdb_valid), .cdb_T_idx(cdb_T_idx),
    .rob_head_idx(rob_head_idx), .rollback_en(rollback_en),
    .rollback_idx(rollback_idx), .rollback_diff(rollback_diff),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_T_idx(issue_T_idx), .issue_T1_idx(issue_T1_idx), .issue_T2_idx(issue_T2_idx),
    .issue_ROB_idx(issue_ROB_idx), .issue_payload(issue_payload),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    disp_T_idx = '0; disp_T1_idx = '0; disp_T2_idx = '0;
    disp_T1_ready = 1'b0; disp_T2_ready = 1'b0;
    disp_ROB_idx = '0; disp_payload = '0;
    cdb_valid = '0; cdb_T_idx = '0;
    rollback_en = 1'b0; rollback_idx = '0; rollback_diff = '0;
    issue_ready = 1'b0;
  endtask

  task automatic disp(input logic [5:0] t, input logic [5:0] t1, input logic r1,
                      input logic [5:0] t2, input logic r2, input logic [4:0] rob);
    dispatch_valid = 1'b1;
    disp_T_idx = t; disp_T1_idx = t1; disp_T2_idx = t2;
    disp_T1_ready = r1; disp_T2_ready = r2;
    disp_ROB_idx = rob;
    disp_payload = 64'hA5A5_0000_0000_0000 | 64'(t);
  endtask

  typedef struct {
    logic       dv;
    logic [5:0] t, t1;
    logic       r1;
    logic [5:0] t2;
    logic       r2;
    logic [4:0] rob;
    logic [1:0] cv;
    logic [5:0] c0, c1;
    logic       ir;
    logic       e_dr, e_iv;
    logic [4:0] e_rob;
    logic [5:0] e_t;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // dv t  t1 r1 t2 r2 rob cv c0 c1 ir | dr iv rob t cnt
    vecs[0] = '{1, 1, 10, 0, 11, 0, 2, 0, 0,  0,  1, 1, 0, 0, 0, 0};
    vecs[1] = '{1, 2, 12, 1, 13, 1, 3, 0, 0,  0,  0, 1, 0, 0, 0, 1};
    vecs[2] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 1, 1, 3, 2, 2};
    vecs[3] = '{0, 0, 0,  0, 0,  0, 0, 1, 10, 0,  0, 1, 1, 3, 2, 2};
    vecs[4] = '{0, 0, 0,  0, 0,  0, 0, 2, 0,  11, 1, 1, 1, 2, 1, 2};
    vecs[5] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  1, 1, 1, 3, 2, 1};
    vecs[6] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0};
    vecs[7] = '{1, 3, 20, 0, 21, 0, 7, 3, 20, 21, 0, 1, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  1, 1, 1, 7, 3, 1};
    vecs[9] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  1, 1, 0, 0, 0, 0};

    // Reset state.
    idle();
    en = 1'b1; rob_head_idx = '0;
    rst_n = 1'b0;
    #2;
    check("reset_count", 64'(count), 64'd0);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_dispatch_ready", 64'(dispatch_ready), 64'd1);
    #1 rst_n = 1'b1;
    tick();

    // Cycle table.
    for (int i = 0; i < 10; i++) begin
      idle();
      if (vecs[i].dv) disp(vecs[i].t, vecs[i].t1, vecs[i].r1, vecs[i].t2, vecs[i].r2, vecs[i].rob);
      cdb_valid   = vecs[i].cv;
      cdb_T_idx   = {vecs[i].c1, vecs[i].c0};
      issue_ready = vecs[i].ir;
      #2;
      check($sformatf("vec%0d_dispatch_ready", i), 64'(dispatch_ready), 64'(vecs[i].e_dr));
      check($sformatf("vec%0d_issue_valid", i), 64'(issue_valid), 64'(vecs[i].e_iv));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      if (vecs[i].e_iv) begin
        check($sformatf("vec%0d_issue_rob", i), 64'(issue_ROB_idx), 64'(vecs[i].e_rob));
        check($sformatf("vec%0d_issue_t", i), 64'(issue_T_idx), 64'(vecs[i].e_t));
      end
      tick();
    end

    // Fill to capacity, 9th dispatch ignored, then squash everything.
    for (int i = 0; i < 8; i++) begin
      idle();
      disp(6'(i), 6'(40 + i), 1'b0, 6'd50, 1'b0, 5'(i));
      issue_ready = 1'b1;
      tick();
    end
    idle();
    disp(6'd33, 6'd1, 1'b1, 6'd2, 1'b1, 5'd8);
    #2;
    check("fill_count", 64'(count), 64'd8);
    check("fill_dispatch_ready", 64'(dispatch_ready), 64'd0);
    check("fill_issue_valid", 64'(issue_valid), 64'd0);
    tick();
    #2;
    check("fill_9th_ignored", 64'(count), 64'd8);
    idle();
    rollback_en = 1'b1; rollback_idx = 5'd0; rollback_diff = 5'd31;
    #1;
    check("squash_all_dispatch_ready", 64'(dispatch_ready), 64'd0);
    tick();
    idle();
    #2;
    check("squash_all_count", 64'(count), 64'd0);

    // Same-cycle CDB bypass on both operands.
    disp(6'd9, 6'd5, 1'b0, 6'd7, 1'b0, 5'd0);
    tick();
    idle();
    #1;
    check("bypass_before_cdb", 64'(issue_valid), 64'd0);
    cdb_valid = 2'b11; cdb_T_idx = {6'd7, 6'd5};
    #1;
    check("bypass_issue_valid", 64'(issue_valid), 64'd1);
    check("bypass_t1", 64'(issue_T1_idx), 64'd5);
    check("bypass_t2", 64'(issue_T2_idx), 64'd7);
    check("bypass_payload", issue_payload, 64'hA5A5_0000_0000_0009);
    tick();
    idle();
    issue_ready = 1'b1;
    #2;
    check("bypass_latched", 64'(issue_valid), 64'd1);
    tick();
    idle();
    #2;
    check("bypass_drained", 64'(count), 64'd0);

    // Age select across the ROB wrap point.
    rob_head_idx = 5'd30;
    disp(6'd11, 6'd1, 1'b1, 6'd2, 1'b1, 5'd1);
    tick();
    disp(6'd12, 6'd1, 1'b1, 6'd2, 1'b1, 5'd31);
    tick();
    idle();
    issue_ready = 1'b1;
    #2;
    check("wrap_first_rob", 64'(issue_ROB_idx), 64'd31);
    tick();
    #2;
    check("wrap_second_rob", 64'(issue_ROB_idx), 64'd1);
    tick();
    #2;
    check("wrap_drained", 64'(count), 64'd0);
    rob_head_idx = 5'd0;

    // Backpressure.
    idle();
    disp(6'd13, 6'd1, 1'b1, 6'd2, 1'b1, 5'd5);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("bp%0d_issue_valid", i), 64'(issue_valid), 64'd1);
      check($sformatf("bp%0d_count", i), 64'(count), 64'd1);
      tick();
    end
    issue_ready = 1'b1;
    #2;
    check("bp_release_valid", 64'(issue_valid), 64'd1);
    tick();
    idle();
    #2;
    check("bp_release_count", 64'(count), 64'd0);

    // Rollback of ROB 4..6 with entries at 3, 4, 5, 9.
    disp(6'd3, 6'd1, 1'b1, 6'd2, 1'b1, 5'd3); tick();
    disp(6'd4, 6'd1, 1'b1, 6'd2, 1'b1, 5'd4); tick();
    disp(6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 5'd5); tick();
    disp(6'd6, 6'd1, 1'b1, 6'd2, 1'b1, 5'd9); tick();
    idle();
    rob_head_idx = 5'd4;
    rollback_en = 1'b1; rollback_idx = 5'd4; rollback_diff = 5'd2;
    #2;
    check("rb_dispatch_ready", 64'(dispatch_ready), 64'd0);
    check("rb_count_before", 64'(count), 64'd4);
    check("rb_issue_valid", 64'(issue_valid), 64'd1);
    check("rb_issue_rob", 64'(issue_ROB_idx), 64'd9);
    tick();
    idle();
    #2;
    check("rb_count_after", 64'(count), 64'd2);
    issue_ready = 1'b1;
    check("rb_next_rob", 64'(issue_ROB_idx), 64'd9);
    tick();
    #2;
    check("rb_last_rob", 64'(issue_ROB_idx), 64'd3);
    tick();
    #2;
    check("rb_drained", 64'(count), 64'd0);
    rob_head_idx = 5'd0;

    // Enable low: nothing fires, CDB and rollback ignored.
    idle();
    disp(6'd14, 6'd1, 1'b1, 6'd2, 1'b1, 5'd6);
    tick();
    en = 1'b0;
    disp(6'd15, 6'd1, 1'b1, 6'd2, 1'b1, 5'd7);
    issue_ready = 1'b1;
    cdb_valid = 2'b11; cdb_T_idx = {6'd1, 6'd2};
    rollback_en = 1'b1; rollback_idx = 5'd6; rollback_diff = 5'd0;
    #2;
    check("en_low_issue_valid", 64'(issue_valid), 64'd0);
    check("en_low_dispatch_ready", 64'(dispatch_ready), 64'd0);
    tick();
    #2;
    check("en_low_count_held", 64'(count), 64'd1);
    en = 1'b1;
    idle();
    issue_ready = 1'b1;
    #2;
    check("en_high_issue_rob", 64'(issue_ROB_idx), 64'd6);
    tick();
    #2;
    check("en_high_drained", 64'(count), 64'd0);

    // Asynchronous reset between edges with five ready entries.
    for (int i = 0; i < 5; i++) begin
      idle();
      disp(6'(20 + i), 6'd1, 1'b1, 6'd2, 1'b1, 5'(10 + i));
      tick();
    end
    idle();
    #1;
    check("pre_reset_count", 64'(count), 64'd5);
    check("pre_reset_issue_valid", 64'(issue_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_count", 64'(count), 64'd0);
    check("async_reset_issue_valid", 64'(issue_valid), 64'd0);
    check("async_reset_dispatch_ready", 64'(dispatch_ready), 64'd1);
    #1 rst_n = 1'b1;
    issue_ready = 1'b1;
    tick();
    #2;
    check("post_reset_issue_valid", 64'(issue_valid), 64'd0);
    check("post_reset_count", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rs_multi.md
RS_MULTI -- requirements
Module: rs_multi

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 8: number of RS entries (power of two, ≥2).
REQ-002 SHALL have parameter NUM_CDB, default 2: number of CDB broadcast ports.
REQ-003 SHALL have parameter NUM_ROB, default 32: ROB depth (power of two); ROB index width is clog2(NUM_ROB).
REQ-004 SHALL have parameter T_W, default 6: physical-register tag width.
REQ-005 SHALL have parameter PAYLOAD_W, default 64: opaque per-op payload width (inst/func/NPC/dest/FL/select bits).
REQ-006 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have ports: en  in  1  stage enable; dispatch_valid  in  1; dispatch_ready  out  1  at least one free entry.
REQ-008 SHALL have dispatch ports: disp_T_idx, disp_T1_idx, disp_T2_idx  in  T_W; disp_T1_ready, disp_T2_ready  in  1; disp_ROB_idx  in  clog2(NUM_ROB); disp_payload  in  PAYLOAD_W.
REQ-009 SHALL have ports: cdb_valid  in  NUM_CDB; cdb_T_idx  in  NUM_CDB*T_W  packed tags, port 0 in LSBs.
REQ-010 SHALL have ports: rob_head_idx  in  clog2(NUM_ROB)  oldest in-flight ROB slot; rollback_en  in  1; rollback_idx, rollback_diff  in  clog2(NUM_ROB).
REQ-011 SHALL have issue ports: issue_valid  out  1; issue_ready  in  1  FU accepts; issue_T_idx, issue_T1_idx, issue_T2_idx  out  T_W; issue_ROB_idx  out  clog2(NUM_ROB); issue_payload  out  PAYLOAD_W.
REQ-012 SHALL have port count  out  clog2(NUM_ENTRY)+1  registered number of valid entries.

Function
REQ-013 Each entry SHALL hold valid, T_idx, T1{idx,ready}, T2{idx,ready}, ROB_idx, payload.
REQ-014 dispatch_ready SHALL = en && !rollback_en && (count < NUM_ENTRY); entries freed in the current cycle SHALL NOT be reusable until the next cycle.
REQ-015 Dispatch fires when dispatch_valid && dispatch_ready; the op SHALL be written to the lowest-index invalid entry at the next rising edge.
REQ-016 Wakeup: an operand SHALL be ready if its stored ready bit is set or any cdb_valid[k] with cdb_T_idx[k] == operand idx (same-cycle bypass); the ready bit SHALL be registered.
REQ-017 A dispatching operand matching any valid CDB tag in the dispatch cycle SHALL be written ready.
REQ-018 Eligible entry: valid, both operands ready per REQ-016, not rolled back per REQ-021.
REQ-019 Select SHALL pick the eligible entry with the smallest age (ROB_idx - rob_head_idx) mod NUM_ROB; issue_valid = en && any eligible; issue_* SHALL present the selected entry combinationally, with issue_T1_idx/issue_T2_idx from stored tags.
REQ-020 An entry SHALL be freed at the edge where issue_valid && issue_ready; while issue_ready is low the same or an older eligible op SHALL remain presented.
REQ-021 Rollback: with rollback_en high, every valid entry with (ROB_idx - rollback_idx) mod NUM_ROB <= rollback_diff SHALL be invalidated at the next edge and excluded from selection that cycle.
REQ-022 count SHALL update as count + dispatch_fire - issue_fire - rollback_squashed; it SHALL never exceed NUM_ENTRY or go below 0.
REQ-023 With en low, all state SHALL hold, issue_valid = 0, dispatch_ready = 0; CDB and rollback inputs SHALL be ignored.
REQ-024 All ROB/age arithmetic SHALL be modulo NUM_ROB (wrap at clog2(NUM_ROB) bits).

Reset
REQ-025 While reset is low, asynchronously: all entries invalid, all ready bits 0, count = 0; issue_valid = 0; dispatch_ready follows REQ-014 (1 when en high and rollback_en low).
REQ-026 Reset deassertion mid-operation SHALL discard all entries; no op issues in the first cycle after release.

Verification
REQ-027 Fill: 8 dispatches with T1/T2 not ready -> count = 8, dispatch_ready = 0; 9th dispatch_valid ignored.
REQ-028 Wakeup bypass: entry T1=5,T2=7 not ready; cdb_valid=2'b11, tags 5 and 7 -> issue_valid = 1 in the same cycle.
REQ-029 Age select with wrap: rob_head=30, ready entries ROB 1 and 31 -> ROB 31 issues first, then ROB 1.
REQ-030 Backpressure: ready entry, issue_ready = 0 for 3 cycles -> issue_valid held, count unchanged; issue_ready = 1 -> freed next edge, count decremented.
REQ-031 Rollback: entries ROB 3,4,5,9, rollback_idx=4, diff=2 -> ROB 4,5 squashed, count 4 -> 2, neither issues that cycle; dispatch_ready = 0 that cycle.
REQ-032 Async reset asserted between edges with 5 entries -> count = 0 and issue_valid = 0 immediately, before the next clock edge.
